// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//   Instruction fetch stage in front of a synchronous-read instruction ROM.
//   Issues ROM word addresses and tracks which PC the one-cycle-late ROM data
//   belongs to. It presents PC/instruction pairs to decode over valid/ready.
//   The ROM is re-read on a stall so that rom_data stays stable.
//
// Ports
//   clk          single clock, shared with the ROM
//   rst          synchronous, active-high reset
//   rom_addr     word address to the ROM instruction port
//   rom_data     ROM read data, valid one cycle after rom_addr
//   fetch_en     1 = issue new fetches, 0 = drain and idle
//   redirect     one-cycle pulse: drop current output, restart at redirect_pc
//   redirect_pc  redirect target byte address (bits [1:0] ignored)
//   out_valid    out_inst/out_pc hold a valid instruction
//   out_ready    downstream accepts this cycle
//   out_inst     instruction word (rom_data passthrough)
//   out_pc       byte PC of out_inst
// -----------------------------------------------------------------------------
module inst_fetch #(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [31:0]           rom_data,
    input  logic                  fetch_en,
    input  logic                  redirect,
    input  logic [31:0]           redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_inst,
    output logic [31:0]           out_pc
);

    // f_pc is the PC whose data is on rom_data this cycle; f_valid marks it live.
    logic [31:0] f_pc;
    logic        f_valid;

    logic [31:0] f_pc_nxt;
    logic        f_valid_nxt;
    logic [31:0] issue_addr;
    logic [31:0] seq_pc;
    logic        cur_valid;
    logic        take_redirect;
    logic        stall;

    // While rst is high, the address path behaves as if nothing is in flight
    // and ignores redirects. The ROM is then already re-pointed at f_pc.
    assign cur_valid     = f_valid & ~rst;
    assign take_redirect = redirect & ~rst;
    assign seq_pc        = cur_valid ? (f_pc + 32'd4) : f_pc;
    assign stall         = cur_valid & ~out_ready;

    always_comb begin
        issue_addr  = seq_pc;
        f_pc_nxt    = seq_pc;
        f_valid_nxt = fetch_en;
        if (take_redirect) begin
            issue_addr  = {redirect_pc[31:2], 2'b00};
            f_pc_nxt    = {redirect_pc[31:2], 2'b00};
            f_valid_nxt = fetch_en;
        end else if (stall) begin
            // Re-read the held word; fetch_en has no effect until it drains.
            issue_addr  = f_pc;
            f_pc_nxt    = f_pc;
            f_valid_nxt = f_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f_pc    <= RESET_PC;
            f_valid <= 1'b0;
        end else begin
            f_pc    <= f_pc_nxt;
            f_valid <= f_valid_nxt;
        end
    end

    // The ROM address wraps at 4*2^ADDR_WIDTH bytes; out_pc keeps full width.
    assign rom_addr  = issue_addr[ADDR_WIDTH+1:2];
    assign out_valid = f_valid & ~redirect;
    assign out_pc    = f_pc;
    assign out_inst  = rom_data;

    // Bits of the address that never reach the ROM port.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{issue_addr[31:ADDR_WIDTH+2], issue_addr[1:0],
                                redirect_pc[1:0]};

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

    localparam int AW = 12;

    logic          clk;
    logic          rst;
    logic [AW-1:0] rom_addr;
    logic [31:0]   rom_data;
    logic          fetch_en;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_inst;
    logic [31:0]   out_pc;

    int n_checks;
    int n_pass;

    inst_fetch #(
        .ADDR_WIDTH(AW),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .fetch_en   (fetch_en),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_inst   (out_inst),
        .out_pc     (out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read ROM with ROM[i] = 32'h1000_0000 + i.
    always @(posedge clk) rom_data <= 32'h1000_0000 + {20'd0, rom_addr};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Advance to just after the next active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full output check, after inputs for this cycle have settled.
    task automatic chk_out(input string tag, input logic v, input logic [31:0] pc,
                           input logic [31:0] inst);
        #1;
        chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
        chk({tag, ".pc"}, out_pc, pc);
        if (v) chk({tag, ".inst"}, out_inst, inst);
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        rst         = 1'b1;
        fetch_en    = 1'b1;
        out_ready   = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'd0;

        tick();
        tick();
        chk_out("reset", 1'b0, 32'h0, 32'h0);

        // cycle 0: reset released, RESET_PC issued
        rst = 1'b0;
        #1;
        chk("c0.rom_addr", {20'd0, rom_addr}, 32'd0);

        // Sequential fetch
        tick(); chk_out("seq1", 1'b1, 32'h0, 32'h1000_0000);
        tick(); chk_out("seq2", 1'b1, 32'h4, 32'h1000_0001);
        tick();
        out_ready = 1'b0;                        // cycle 3: stall begins
        chk_out("stall0", 1'b1, 32'h8, 32'h1000_0002);
        chk("stall0.rom_addr", {20'd0, rom_addr}, 32'd2);
        for (int i = 1; i < 3; i++) begin
            tick();
            chk_out("stall", 1'b1, 32'h8, 32'h1000_0002);
            chk("stall.rom_addr", {20'd0, rom_addr}, 32'd2);
        end
        tick();
        out_ready = 1'b1;                        // held word accepted now
        chk_out("stall_acc", 1'b1, 32'h8, 32'h1000_0002);
        tick(); chk_out("after_stall", 1'b1, 32'hC, 32'h1000_0003);

        // Redirect to 0x43 while out_pc = 0x10
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h43;
        chk_out("redir", 1'b0, 32'h10, 32'h0);
        chk("redir.rom_addr", {20'd0, rom_addr}, 32'h10);
        tick();
        redirect = 1'b0;
        chk_out("redir_tgt", 1'b1, 32'h40, 32'h1000_0010);
        tick(); chk_out("redir_seq", 1'b1, 32'h44, 32'h1000_0011);

        // fetch_en: land on 0x20, drop enable as it is accepted
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h20;
        #1;
        tick();
        redirect = 1'b0;
        fetch_en = 1'b0;
        chk_out("fe_acc", 1'b1, 32'h20, 32'h1000_0008);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("fe_off", 1'b0, 32'h24, 32'h0);
        end
        tick();
        fetch_en = 1'b1;
        chk_out("fe_reen", 1'b0, 32'h24, 32'h0);
        tick(); chk_out("fe_resume", 1'b1, 32'h24, 32'h1000_0009);

        // Wrap of the ROM address at 0x4000
        redirect    = 1'b1;
        redirect_pc = 32'h3FFC;
        #1;
        tick();
        redirect = 1'b0;
        chk_out("wrap0", 1'b1, 32'h3FFC, 32'h1000_0FFF);
        chk("wrap0.rom_addr", {20'd0, rom_addr}, 32'd0);
        tick(); chk_out("wrap1", 1'b1, 32'h4000, 32'h1000_0000);

        // Reset during a stall
        out_ready = 1'b0;
        rst       = 1'b1;
        #1;
        chk("rst_stall.valid_before", {31'd0, out_valid}, 32'd1);
        tick();
        rst = 1'b0;
        chk_out("rst_stall", 1'b0, 32'h0, 32'h0);
        chk("rst_stall.rom_addr", {20'd0, rom_addr}, 32'd0);
        out_ready = 1'b1;
        tick(); chk_out("rst_resume0", 1'b1, 32'h0, 32'h1000_0000);
        tick(); chk_out("rst_resume1", 1'b1, 32'h4, 32'h1000_0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
